// File: rtl/vram_scan_arbiter.sv
// vram_scan_arbiter
// Owns the single-port frame-buffer RAM. VGA scanout takes every even pixel
// of the active area, and the CPU port uses the remaining slots. RAM accesses
// return three cycles after the grant, and the syncs are delayed by three
// cycles so that pix_data lines up with them.
module vram_scan_arbiter #(
   parameter int FB_W   = 320,
   parameter int FB_H   = 240,
   parameter int DATA_W = 8,
   parameter int ADDR_W = 17
) (
   input  logic              vgaclk,
   input  logic              reset,
   input  logic [9:0]        hcnt,
   input  logic [9:0]        vcnt,
   input  logic              hsync_i,
   input  logic              vsync_i,
   input  logic              blank_b_i,
   output logic              hsync_o,
   output logic              vsync_o,
   output logic              blank_b_o,
   output logic [DATA_W-1:0] pix_data,
   input  logic              cpu_valid,
   output logic              cpu_ready,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [ADDR_W-1:0] FB_SIZE  = ADDR_W'(FB_W * FB_H);
   localparam logic [ADDR_W-1:0] FB_WIDTH = ADDR_W'(FB_W);

   // Each tag describes what the RAM returns for one slot. The tag travels
   // alongside the access for two stages.
   typedef enum logic [1:0] {
      TAG_NONE = 2'd0,
      TAG_SCAN = 2'd1,
      TAG_CPU  = 2'd2,
      TAG_ZERO = 2'd3   // CPU read outside the frame buffer: answer 0
   } tag_t;

   logic              scan_slot;
   logic [ADDR_W-1:0] scan_addr;
   logic              accept;
   logic              grant;

   logic              req_vld;
   logic              req_we;
   logic              req_oor;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;

   logic [ADDR_W-1:0] mem_addr_nxt;
   logic              mem_we_nxt;
   logic [DATA_W-1:0] mem_wdata_nxt;
   tag_t              tag_nxt;
   tag_t              tag_q1;
   tag_t              tag_q2;

   logic [2:0]        hsync_dly;
   logic [2:0]        vsync_dly;
   logic [2:0]        blank_dly;
   logic [DATA_W-1:0] pix_q;

   // Scanout owns the even pixels of the active area. Every other cycle is free.
   assign scan_slot = blank_b_i & ~hcnt[0];
   // Each frame-buffer pixel is shown as a 2x2 block, so the raster counts are halved.
   assign scan_addr = ADDR_W'(vcnt >> 1) * FB_WIDTH + ADDR_W'(hcnt >> 1);

   assign cpu_ready = ~req_vld;
   assign accept    = cpu_valid & ~req_vld;
   assign grant     = req_vld & ~scan_slot;

   // Choose the next RAM access for this slot: scanout first, otherwise the pending CPU request.
   always_comb begin
      mem_addr_nxt  = mem_addr;
      mem_we_nxt    = 1'b0;
      mem_wdata_nxt = mem_wdata;
      tag_nxt       = TAG_NONE;
      if (scan_slot) begin
         mem_addr_nxt = scan_addr;
         tag_nxt      = TAG_SCAN;
      end else if (req_vld) begin
         mem_addr_nxt  = req_addr;
         mem_wdata_nxt = req_wdata;
         mem_we_nxt    = req_we & ~req_oor;
         if (!req_we) begin
            tag_nxt = req_oor ? TAG_ZERO : TAG_CPU;
         end
      end
   end

   // Register the RAM port and advance the return-tag pipe.
   always_ff @(posedge vgaclk or negedge reset) begin
      if (!reset) begin
         mem_addr  <= '0;
         mem_we    <= 1'b0;
         mem_wdata <= '0;
         tag_q1    <= TAG_NONE;
         tag_q2    <= TAG_NONE;
      end else begin
         mem_addr  <= mem_addr_nxt;
         mem_we    <= mem_we_nxt;
         mem_wdata <= mem_wdata_nxt;
         tag_q1    <= tag_nxt;
         tag_q2    <= tag_q1;
      end
   end

   // One-entry CPU holding register. Accept and grant never fall in the same cycle.
   always_ff @(posedge vgaclk or negedge reset) begin
      if (!reset) begin
         req_vld   <= 1'b0;
         req_we    <= 1'b0;
         req_oor   <= 1'b0;
         req_addr  <= '0;
         req_wdata <= '0;
      end else if (accept) begin
         req_vld   <= 1'b1;
         req_we    <= cpu_we;
         req_oor   <= (cpu_addr >= FB_SIZE);
         req_addr  <= cpu_addr;
         req_wdata <= cpu_wdata;
      end else if (grant) begin
         req_vld   <= 1'b0;
      end
   end

   // Capture returning RAM data into the pixel or CPU read register.
   always_ff @(posedge vgaclk or negedge reset) begin
      if (!reset) begin
         pix_q      <= '0;
         cpu_rvalid <= 1'b0;
         cpu_rdata  <= '0;
      end else begin
         cpu_rvalid <= (tag_q2 == TAG_CPU) || (tag_q2 == TAG_ZERO);
         if (tag_q2 == TAG_SCAN) begin
            pix_q <= mem_rdata;
         end
         if (tag_q2 == TAG_CPU) begin
            cpu_rdata <= mem_rdata;
         end else if (tag_q2 == TAG_ZERO) begin
            cpu_rdata <= '0;
         end
      end
   end

   // Delay the timing signals by three cycles to match the pixel latency.
   always_ff @(posedge vgaclk or negedge reset) begin
      if (!reset) begin
         hsync_dly <= '1;
         vsync_dly <= '1;
         blank_dly <= '0;
      end else begin
         hsync_dly <= {hsync_dly[1:0], hsync_i};
         vsync_dly <= {vsync_dly[1:0], vsync_i};
         blank_dly <= {blank_dly[1:0], blank_b_i};
      end
   end

   assign hsync_o   = hsync_dly[2];
   assign vsync_o   = vsync_dly[2];
   assign blank_b_o = blank_dly[2];
   assign pix_data  = blank_b_o ? pix_q : '0;

endmodule

// File: tb/tb_vram_scan_arbiter.sv
// Bench for vram_scan_arbiter. It contains a RAM model, a transaction-level
// reference model, a per-cycle compare and directed scenarios.
module tb_vram_scan_arbiter;
   localparam int FBW = 320;
   localparam int FBN = 320 * 240;

   logic        vgaclk = 1'b0;
   logic        reset = 1'b0;
   logic [9:0]  hcnt = '0;
   logic [9:0]  vcnt = '0;
   logic        hsync_i = 1'b1;
   logic        vsync_i = 1'b1;
   logic        blank_b_i = 1'b0;
   logic        hsync_o, vsync_o, blank_b_o;
   logic [7:0]  pix_data;
   logic        cpu_valid = 1'b0;
   logic        cpu_ready;
   logic        cpu_we = 1'b0;
   logic [16:0] cpu_addr = '0;
   logic [7:0]  cpu_wdata = '0;
   logic        cpu_rvalid;
   logic [7:0]  cpu_rdata;
   logic [16:0] mem_addr;
   logic        mem_we;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata = '0;

   vram_scan_arbiter dut (
      .vgaclk(vgaclk), .reset(reset), .hcnt(hcnt), .vcnt(vcnt),
      .hsync_i(hsync_i), .vsync_i(vsync_i), .blank_b_i(blank_b_i),
      .hsync_o(hsync_o), .vsync_o(vsync_o), .blank_b_o(blank_b_o),
      .pix_data(pix_data), .cpu_valid(cpu_valid), .cpu_ready(cpu_ready),
      .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .mem_addr(mem_addr),
      .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 vgaclk = ~vgaclk;

   function automatic logic [7:0] init_val(int a);
      return 8'(a * 13 + 1);
   endfunction

   // Synchronous single-port RAM: one cycle of read latency.
   logic [7:0] ram    [0:131071];
   bit         ram_wr [0:131071];
   always @(posedge vgaclk) begin
      if (mem_we) begin
         ram[mem_addr]    <= mem_wdata;
         ram_wr[mem_addr] <= 1'b1;
      end
      mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : init_val(int'(mem_addr));
   end

   // Reference model. Each slot is classified from the raster inputs.
   // Accesses are applied to a shadow frame buffer in slot order, and each
   // return is scheduled three periods after its grant.
   typedef struct packed {
      logic        we;
      logic [16:0] addr;
      logic [7:0]  wd;
   } req_t;

   logic [7:0]  mfb    [0:131071];
   bit          mfb_wr [0:131071];
   bit          m_pend = 1'b0;
   req_t        m_req  = '0;
   logic [16:0] m_ma   = '0;
   bit          m_we   = 1'b0;
   logic [7:0]  m_wd   = '0;
   logic [7:0]  m_pix  = '0;
   bit          m_rv   = 1'b0;
   logic [7:0]  m_rd   = '0;
   bit          hsq[$] = '{1'b1, 1'b1, 1'b1};
   bit          vsq[$] = '{1'b1, 1'b1, 1'b1};
   bit          blq[$] = '{1'b0, 1'b0, 1'b0};
   int          ev_kind [16];
   logic [7:0]  ev_data [16];
   int          pcur = 0;

   function automatic logic [7:0] mval(int a);
      return mfb_wr[a] ? mfb[a] : init_val(a);
   endfunction

   always @(posedge vgaclk or negedge reset) begin : model
      int  a;
      bit  rdy;
      bit  oor;
      int  s;
      if (!reset) begin
         m_pend = 1'b0; m_ma = '0; m_we = 1'b0; m_wd = '0;
         m_pix = '0; m_rv = 1'b0; m_rd = '0;
         hsq = '{1'b1, 1'b1, 1'b1};
         vsq = '{1'b1, 1'b1, 1'b1};
         blq = '{1'b0, 1'b0, 1'b0};
         for (int i = 0; i < 16; i++) ev_kind[i] = 0;
      end else begin
         rdy = !m_pend;
         s   = (pcur + 3) % 16;
         if (blank_b_i && (hcnt % 2 == 0)) begin
            a = (int'(vcnt) / 2) * FBW + int'(hcnt) / 2;
            m_ma = 17'(a);
            m_we = 1'b0;
            ev_kind[s] = 1;
            ev_data[s] = mval(a);
         end else if (m_pend) begin
            a    = int'(m_req.addr);
            oor  = (a >= FBN);
            m_ma = m_req.addr;
            m_wd = m_req.wd;
            m_we = m_req.we && !oor;
            if (m_req.we) begin
               if (!oor) begin
                  mfb[a]    = m_req.wd;
                  mfb_wr[a] = 1'b1;
               end
            end else begin
               ev_kind[s] = 2;
               ev_data[s] = oor ? 8'h00 : mval(a);
            end
            m_pend = 1'b0;
         end else begin
            m_we = 1'b0;
         end
         if (cpu_valid && rdy) begin
            m_pend = 1'b1;
            m_req  = '{we: cpu_we, addr: cpu_addr, wd: cpu_wdata};
         end
         hsq.push_back(hsync_i);   void'(hsq.pop_front());
         vsq.push_back(vsync_i);   void'(vsq.pop_front());
         blq.push_back(blank_b_i); void'(blq.pop_front());
         pcur = pcur + 1;
         s = pcur % 16;
         m_rv = (ev_kind[s] == 2);
         if (ev_kind[s] == 1) m_pix = ev_data[s];
         if (ev_kind[s] == 2) m_rd = ev_data[s];
         ev_kind[s] = 0;
      end
   end

   int   checks = 0;
   int   errors = 0;
   req_t rq[$];
   int   ras_h = 0;
   int   ras_v = 0;
   bit   ras_en = 1'b0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s period %0d: got %0h expected %0h", nm, pcur, act, exp);
      end
   endtask

   task automatic compare_all();
      chk("hsync_o", 32'(hsync_o), 32'(hsq[0]));
      chk("vsync_o", 32'(vsync_o), 32'(vsq[0]));
      chk("blank_b_o", 32'(blank_b_o), 32'(blq[0]));
      chk("pix_data", 32'(pix_data), 32'(blq[0] ? m_pix : 8'h00));
      chk("cpu_ready", 32'(cpu_ready), 32'(!m_pend));
      chk("cpu_rvalid", 32'(cpu_rvalid), 32'(m_rv));
      chk("mem_we", 32'(mem_we), 32'(m_we));
      chk("mem_addr", 32'(mem_addr), 32'(m_ma));
      if (m_we) chk("mem_wdata", 32'(mem_wdata), 32'(m_wd));
      if (m_rv) chk("cpu_rdata", 32'(cpu_rdata), 32'(m_rd));
   endtask

   task automatic drive_ras();
      hcnt      = 10'(ras_h);
      vcnt      = 10'(ras_v);
      blank_b_i = (ras_h < 640) && (ras_v < 480);
      hsync_i   = !(ras_h >= 656 && ras_h < 752);
      vsync_i   = !(ras_v == 490 || ras_v == 491);
   endtask

   task automatic set_ras(int h, int v, bit en);
      ras_h  = h;
      ras_v  = v;
      ras_en = en;
      drive_ras();
   endtask

   task automatic push_req(bit we, int addr, logic [7:0] wd);
      rq.push_back('{we: we, addr: 17'(addr), wd: wd});
   endtask

   // Compare at mid-period, then move to the next period and drive new inputs.
   task automatic tick();
      bit acc;
      @(negedge vgaclk);
      compare_all();
      acc = cpu_valid && cpu_ready && reset;
      @(posedge vgaclk);
      #1;
      if (acc) void'(rq.pop_front());
      if (ras_en) begin
         ras_h++;
         if (ras_h == 800) begin
            ras_h = 0;
            ras_v = (ras_v == 524) ? 0 : ras_v + 1;
         end
      end
      drive_ras();
      if (rq.size() > 0) begin
         cpu_valid = 1'b1;
         cpu_we    = rq[0].we;
         cpu_addr  = rq[0].addr;
         cpu_wdata = rq[0].wd;
      end else begin
         cpu_valid = 1'b0;
      end
   endtask

   initial begin : stim
      int   we_at[$];
      logic [7:0] rd_seen[$];
      bit   found;
      logic [7:0] got;

      // 1: reset values, a read in flight dropped by reset, first scan after release
      set_ras(90, 0, 1'b1);
      repeat (3) tick();
      chk("t1_rst_ready", 32'(cpu_ready), 32'd1);
      chk("t1_rst_hsync", 32'(hsync_o), 32'd1);
      chk("t1_rst_vsync", 32'(vsync_o), 32'd1);
      chk("t1_rst_blank", 32'(blank_b_o), 32'd0);
      chk("t1_rst_pix", 32'(pix_data), 32'd0);
      chk("t1_rst_maddr", 32'(mem_addr), 32'd0);
      chk("t1_rst_mwe", 32'(mem_we), 32'd0);
      reset = 1'b1;
      push_req(1'b0, 0, 8'h00);
      repeat (4) tick();            // now at hcnt 97, read granted at 95
      reset = 1'b0;
      tick();                       // hcnt 98: its return would have landed here
      chk("t1_dropped_rvalid", 32'(cpu_rvalid), 32'd0);
      tick();                       // hcnt 99
      reset = 1'b1;
      tick();                       // hcnt 100: first scan slot
      tick();                       // hcnt 101
      chk("t1_first_scan_addr", 32'(mem_addr), 32'd50);
      chk("t1_first_scan_we", 32'(mem_we), 32'd0);

      // 2: CPU write of pixel (5,3), then scan it at hcnt 10, vcnt 6
      set_ras(700, 10, 1'b0);
      push_req(1'b1, 3 * 320 + 5, 8'hA5);
      repeat (6) tick();
      set_ras(0, 6, 1'b1);
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (hcnt == 10'd13) found = 1'b1;
         else tick();
      end
      chk("t2_reach_h13", 32'(found), 32'd1);
      chk("t2_pix_h13", 32'(pix_data), 32'hA5);
      chk("t2_blank_h13", 32'(blank_b_o), 32'd1);
      tick();
      chk("t2_pix_h14", 32'(pix_data), 32'hA5);
      chk("t2_blank_h14", 32'(blank_b_o), 32'd1);

      // 3: CPU read of address 0 during blanking
      set_ras(700, 20, 1'b0);
      push_req(1'b1, 0, 8'h3C);
      repeat (6) tick();
      push_req(1'b0, 0, 8'h00);
      tick();                       // period A: request presented
      for (int i = 0; i < 8; i++) begin
         chk("t3_ready", 32'(cpu_ready), (i == 1) ? 32'd0 : 32'd1);
         chk("t3_rvalid", 32'(cpu_rvalid), (i == 4) ? 32'd1 : 32'd0);
         if (i == 4) chk("t3_rdata", 32'(cpu_rdata), 32'h3C);
         tick();
      end

      // 4: CPU writes offered every cycle in the active area
      set_ras(0, 40, 1'b1);
      for (int k = 0; k < 8; k++) push_req(1'b1, 6410 + k, 8'(8'h40 + k));
      for (int n = 0; n < 30; n++) begin
         tick();
         if (mem_we) we_at.push_back(n);
      end
      chk("t4_grant_count", 32'(we_at.size()), 32'd8);
      for (int k = 1; k < we_at.size(); k++)
         chk("t4_grant_spacing", 32'(we_at[k] - we_at[k-1]), 32'd2);
      repeat (30) tick();           // scan the written pixels back

      // 5: out-of-range write and read
      set_ras(700, 30, 1'b0);
      push_req(1'b1, FBN, 8'hEE);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("t5_oor_we", 32'(mem_we), 32'd0);
      end
      chk("t5_oor_handshake", 32'(rq.size()), 32'd0);
      chk("t5_oor_ready", 32'(cpu_ready), 32'd1);
      push_req(1'b0, FBN, 8'h00);
      found = 1'b0;
      got   = 8'hFF;
      for (int i = 0; i < 10 && !found; i++) begin
         tick();
         if (cpu_rvalid) begin
            found = 1'b1;
            got   = cpu_rdata;
         end
      end
      chk("t5_oor_rvalid_seen", 32'(found), 32'd1);
      chk("t5_oor_rdata", 32'(got), 32'd0);

      // 6: two back-to-back reads return in order
      set_ras(0, 60, 1'b1);
      push_req(1'b1, 7, 8'h77);
      push_req(1'b1, 9, 8'h99);
      repeat (10) tick();
      push_req(1'b0, 7, 8'h00);
      push_req(1'b0, 9, 8'h00);
      for (int i = 0; i < 20; i++) begin
         tick();
         if (cpu_rvalid) rd_seen.push_back(cpu_rdata);
      end
      chk("t6_rvalid_count", 32'(rd_seen.size()), 32'd2);
      if (rd_seen.size() == 2) begin
         chk("t6_first_rdata", 32'(rd_seen[0]), 32'h77);
         chk("t6_second_rdata", 32'(rd_seen[1]), 32'h99);
      end

      // Run across the line end and through blanking.
      set_ras(630, 61, 1'b1);
      repeat (200) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
